// File: rtl/intersection_phase_scheduler_if.sv
// Signal-head and pedestrian bundle for one intersection.
// The master drives the advance enable and the pedestrian request; the slave drives the heads, walk, ack and phase.
interface intersection_phase_scheduler_if;
   logic       en;
   logic       ped_req;
   logic [2:0] ns_lights;
   logic [2:0] ew_lights;
   logic       walk;
   logic       ped_ack;
   logic [2:0] phase;

   modport master (
      output en, ped_req,
      input  ns_lights, ew_lights, walk, ped_ack, phase
   );

   modport slave (
      input  en, ped_req,
      output ns_lights, ew_lights, walk, ped_ack, phase
   );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Two-road phase sequencer with a timed green/yellow/all-red cycle.
// A latched pedestrian request inserts a walk phase after RED_B.
module intersection_phase_scheduler #(
   parameter int unsigned GREEN_CYC  = 8,
   parameter int unsigned YELLOW_CYC = 2,
   parameter int unsigned ALLRED_CYC = 1,
   parameter int unsigned WALK_CYC   = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   intersection_phase_scheduler_if.slave  bus
);

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      RED_A     = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      RED_B     = 3'd5,
      WALK      = 3'd6
   } phase_t;

   phase_t             state, state_nxt, succ;
   logic               legal;
   logic [CNT_W-1:0]   timer, timer_nxt;
   logic               pending, pending_nxt;
   logic               ack, ack_nxt;

   function automatic logic [CNT_W-1:0] dur_m1(input phase_t p);
      case (p)
         NS_GREEN, EW_GREEN:   dur_m1 = CNT_W'(GREEN_CYC - 1);
         NS_YELLOW, EW_YELLOW: dur_m1 = CNT_W'(YELLOW_CYC - 1);
         WALK:                 dur_m1 = CNT_W'(WALK_CYC - 1);
         default:              dur_m1 = CNT_W'(ALLRED_CYC - 1);
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RED_B;
         timer   <= CNT_W'(ALLRED_CYC - 1);
         pending <= 1'b0;
         ack     <= 1'b0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         pending <= pending_nxt;
         ack     <= ack_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      pending_nxt = pending | bus.ped_req;
      ack_nxt     = 1'b0;
      succ        = RED_B;
      legal       = 1'b1;

      case (state)
         NS_GREEN:  succ = NS_YELLOW;
         NS_YELLOW: succ = RED_A;
         RED_A:     succ = EW_GREEN;
         EW_GREEN:  succ = EW_YELLOW;
         EW_YELLOW: succ = RED_B;
         RED_B:     succ = pending ? WALK : NS_GREEN;
         WALK:      succ = NS_GREEN;
         default:   legal = 1'b0;
      endcase

      // Illegal code recovers regardless of enable; otherwise advance only when enabled.
      if (!legal) begin
         state_nxt = RED_B;
         timer_nxt = dur_m1(RED_B);
      end else if (bus.en) begin
         if (timer == '0) begin
            state_nxt = succ;
            timer_nxt = dur_m1(succ);
            if (succ == WALK) begin
               // Request on the accepting edge counts as served.
               pending_nxt = 1'b0;
               ack_nxt     = 1'b1;
            end
         end else begin
            timer_nxt = timer - 1'b1;
         end
      end
   end

   always_comb begin
      bus.ns_lights = 3'b100;
      bus.ew_lights = 3'b100;
      bus.walk      = 1'b0;
      case (state)
         NS_GREEN:  bus.ns_lights = 3'b001;
         NS_YELLOW: bus.ns_lights = 3'b010;
         EW_GREEN:  bus.ew_lights = 3'b001;
         EW_YELLOW: bus.ew_lights = 3'b010;
         WALK:      bus.walk      = 1'b1;
         default:   ;
      endcase
   end

   assign bus.phase   = state;
   assign bus.ped_ack = ack;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboarded directed bench for intersection_phase_scheduler: default and fast-parameter instances.
// An age-counting reference predicts each edge's outputs; a negedge monitor checks head legality.
module tb_intersection_phase_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_f = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   intersection_phase_scheduler_if b ();
   intersection_phase_scheduler_if f ();

   intersection_phase_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (b)
   );

   intersection_phase_scheduler #(
      .GREEN_CYC  (1),
      .YELLOW_CYC (1),
      .ALLRED_CYC (1)
   ) dut_fast (
      .clk (clk),
      .rst (rst_f),
      .bus (f)
   );

   typedef struct packed {
      logic [2:0] phase;
      logic [2:0] ns;
      logic [2:0] ew;
      logic       walk;
      logic       ack;
   } exp_t;

   exp_t sb[$];
   int   fq[$];

   int m_phase, m_age;
   bit m_pend;

   function automatic int dur(input int p);
      case (p)
         0, 3:    return 8;
         1, 4:    return 2;
         6:       return 4;
         default: return 1;
      endcase
   endfunction

   function automatic exp_t mk(input int p, input bit a);
      exp_t e;
      e.phase = 3'(p);
      e.ns    = 3'b100;
      e.ew    = 3'b100;
      e.walk  = (p == 6);
      e.ack   = a;
      if (p == 0) e.ns = 3'b001;
      if (p == 1) e.ns = 3'b010;
      if (p == 3) e.ew = 3'b001;
      if (p == 4) e.ew = 3'b010;
      return e;
   endfunction

   function automatic bit legal_heads(input logic [2:0] ns, input logic [2:0] ew);
      bit ok_ns, ok_ew;
      ok_ns = (ns == 3'b001) || (ns == 3'b010) || (ns == 3'b100);
      ok_ew = (ew == 3'b001) || (ew == 3'b010) || (ew == 3'b100);
      return ok_ns && ok_ew && ((ns == 3'b100) || (ew == 3'b100));
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Predict the state after the coming edge and queue it.
   task automatic model_edge(input bit e, input bit r);
      bit served, a;
      served = 0;
      a      = 0;
      if (e) begin
         if (m_age + 1 >= dur(m_phase)) begin
            if (m_phase == 5 && m_pend) begin
               m_phase = 6;
               m_pend  = 0;
               a       = 1;
               served  = 1;
            end else if (m_phase == 5 || m_phase == 6) begin
               m_phase = 0;
            end else begin
               m_phase = m_phase + 1;
            end
            m_age = 0;
         end else begin
            m_age++;
         end
      end
      if (r && !served) m_pend = 1;
      sb.push_back(mk(m_phase, a));
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         chk("phase", 8'(b.phase), 8'(e.phase));
         chk("ns_lights", 8'(b.ns_lights), 8'(e.ns));
         chk("ew_lights", 8'(b.ew_lights), 8'(e.ew));
         chk("walk", 8'(b.walk), 8'(e.walk));
         chk("ped_ack", 8'(b.ped_ack), 8'(e.ack));
      end
   endtask

   task automatic step(input bit e, input bit r);
      b.en      = e;
      b.ped_req = r;
      model_edge(e, r);
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic run(input int n, input bit r);
      for (int i = 0; i < n; i++) step(1'b1, r);
   endtask

   task automatic do_reset();
      b.en      = 1'b0;
      b.ped_req = 1'b0;
      rst       = 1'b1;
      #2;
      chk("rst_phase", 8'(b.phase), 8'd5);
      chk("rst_ns", 8'(b.ns_lights), 8'h4);
      chk("rst_ew", 8'(b.ew_lights), 8'h4);
      chk("rst_walk", 8'(b.walk), 8'd0);
      chk("rst_ack", 8'(b.ped_ack), 8'd0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      m_phase = 5;
      m_age   = 0;
      m_pend  = 0;
      sb.delete();
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         tests++;
         assert (legal_heads(b.ns_lights, b.ew_lights)) else begin
            fails++;
            $error("FAIL heads_legal observed=%b/%b expected=legal", b.ns_lights, b.ew_lights);
         end
      end
      if (!rst_f) begin
         tests++;
         assert (legal_heads(f.ns_lights, f.ew_lights)) else begin
            fails++;
            $error("FAIL fast_heads_legal observed=%b/%b expected=legal", f.ns_lights, f.ew_lights);
         end
      end
   end

   initial begin
      f.en      = 1'b0;
      f.ped_req = 1'b0;
      @(posedge clk);
      #1;

      // Free run: one full 22-cycle period plus wrap.
      do_reset();
      run(24, 1'b0);

      // Single request at edge 4; walk edges 23-26, then a plain cycle.
      do_reset();
      run(3, 1'b0);
      step(1'b1, 1'b1);
      run(46, 1'b0);

      // Request held high: walk every cycle.
      do_reset();
      run(60, 1'b1);

      // Freeze five cycles in NS_YELLOW with a request pulsed mid-freeze.
      do_reset();
      run(9, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      run(24, 1'b0);

      // Async reset mid-EW_GREEN drops a latched request.
      do_reset();
      run(3, 1'b0);
      step(1'b1, 1'b1);
      run(10, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      chk("async_phase", 8'(b.phase), 8'd5);
      chk("async_ns", 8'(b.ns_lights), 8'h4);
      chk("async_ew", 8'(b.ew_lights), 8'h4);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      m_phase = 5;
      m_age   = 0;
      m_pend  = 0;
      sb.delete();
      run(30, 1'b0);

      // Fast parameters: one cycle per phase, period 6.
      rst_f = 1'b0;
      f.en  = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         fq.push_back((k - 1) % 6);
         @(posedge clk);
         #1;
         if (fq.size() != 0) begin
            int ep;
            ep = fq.pop_front();
            chk("fast_phase", 8'(f.phase), 8'(ep));
            chk("fast_walk", 8'(f.walk), 8'd0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Two-road intersection sequencer that drives a north-south and an east-west signal head. Green, yellow, all-red and pedestrian-walk phases are timed from parameterised cycle counts, and a latched pedestrian request inserts a walk phase. It sits above the single-head light FSMs and owns all phase timing for one intersection.

## Interface
- GREEN_CYC, 8, cycles per green phase (≥1)
- YELLOW_CYC, 2, cycles per yellow phase (≥1)
- ALLRED_CYC, 1, cycles per all-red clearance phase (≥1)
- WALK_CYC, 4, cycles per pedestrian walk phase (≥1)
- CNT_W, 8, phase timer width; every *_CYC must be ≤ 2^CNT_W
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  timer/FSM advance enable; low freezes phase and timer
- ped_req  in  1  pedestrian request, sampled every edge (pulse or level)
- ns_lights  out  3  north-south head {R,Y,G}
- ew_lights  out  3  east-west head {R,Y,G}
- walk  out  1  pedestrian walk indication
- ped_ack  out  1  one-cycle pulse: pending request accepted
- phase  out  3  current phase code (see Operation)

## Operation
- Phase codes: 0 NS_GREEN, 1 NS_YELLOW, 2 RED_A, 3 EW_GREEN, 4 EW_YELLOW, 5 RED_B, 6 WALK. Code 7 is illegal and recovers to RED_B on the next edge.
- Sequence: NS_GREEN → NS_YELLOW → RED_A → EW_GREEN → EW_YELLOW → RED_B → (pending ? WALK : NS_GREEN). WALK → NS_GREEN.
- Light decode is combinational from phase:
  - NS_GREEN: ns=001, ew=100
  - NS_YELLOW: ns=010, ew=100
  - EW_GREEN: ns=100, ew=001
  - EW_YELLOW: ns=100, ew=010
  - RED_A, RED_B, WALK: ns=ew=100
- walk=1 only in WALK. Never 011, 110, 000 or any green/green combination.
- Phase timer: loaded with duration−1 on phase entry. Decrements on each edge with en=1. When en=1 and timer==0, the FSM transitions. Each phase therefore lasts exactly its *_CYC enabled cycles.
- Pending flag:
  - Set on any edge with ped_req=1.
  - Cleared on the RED_B→WALK edge. ped_req on that same edge is treated as served and does not re-set the flag.
  - Requests during WALK are held for the next RED_B exit.
  - ped_req is latched even while en=0.
- ped_ack: registered, 1 exactly during the first WALK cycle.
- en=0: phase, timer and outputs hold. ped_ack still deasserts after one cycle.

## Timing
- Reset values: phase=RED_B, timer=ALLRED_CYC−1, pending=0, ns=ew=100, walk=0, ped_ack=0.
- Reset asserted mid-phase forces reset values immediately, without waiting for a clock edge. Any pending request is discarded.
- Edge numbering below counts enabled edges after rst deasserts, using default parameters.
- Without a request, states after each edge:
  - edge 1: NS_GREEN (edges 1–8)
  - edge 9: NS_YELLOW (edges 9–10)
  - edge 11: RED_A
  - edge 12: EW_GREEN (edges 12–19)
  - edge 20: EW_YELLOW (edges 20–21)
  - edge 22: RED_B
  - edge 23: NS_GREEN
  - Period = 2·(G+Y+AR) = 22 cycles.
- With a request pending at edge 22: edge 23 enters WALK (edges 23–26), edge 27 enters NS_GREEN.
- Outputs change in the same cycle as phase. No added latency.

## Test plan
- Reset then free run: ns/ew follow the edge-1/9/11/12/20/22/23 schedule above; phase codes 0,1,2,3,4,5,0; walk=0; ped_ack=0 throughout.
- One-cycle ped_req at edge 4 (NS_GREEN): WALK edges 23–26 with walk=1, ns=ew=100; ped_ack=1 only after edge 23; NS_GREEN at edge 27; next cycle (no request) has no WALK.
- ped_req held high continuously: WALK inserted every cycle. The edge-23 request is counted as served; requests latched during WALK trigger the next WALK. Cycle length 26.
- en=0 for 5 cycles starting in NS_YELLOW: yellow persists 7 cycles total, timer frozen. A ped_req pulsed during the freeze is still serviced at the next RED_B.
- Async rst pulse mid-EW_GREEN (between edges): ns=ew=100 and phase=5 immediately. A previously latched request is dropped, so no WALK follows.
- Parameter override GREEN_CYC=1, YELLOW_CYC=1, ALLRED_CYC=1: period 6 cycles, each phase exactly one cycle. No illegal light combination is ever observed (assertion).
